// File: rtl/seg_swt_ctl.sv
// Segment-switch controller for the two-half rename-table unit.
// Watches the architectural half of the issue queue drain, pulses the
// switch, flips the architectural half, and clears retired or flushed
// halves so the queue can refill them.
module seg_swt_ctl #(
  parameter int ISQ_DEPTH = 64,
  parameter int TMO_CYC   = 1023,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISQ_DEPTH-1:0] lin_vld,
  input  logic [ISQ_DEPTH-1:0] lin_done,
  input  logic                 brn_pnd,
  input  logic                 flush,
  output logic                 arch_swt,
  output logic                 arch,
  output logic                 top_clr,
  output logic                 mid_clr,
  output logic                 alloc_stall,
  output logic [CNT_W-1:0]     swt_cnt,
  output logic                 tmo_err
);

  localparam int HALF  = ISQ_DEPTH / 2;
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_SWT,
    S_CLR
  } state_t;

  state_t           state_q, state_d;
  logic             arch_q, arch_d;
  logic [CNT_W-1:0] swt_cnt_q, swt_cnt_d;
  logic             tmo_q, tmo_d;
  logic [TMO_W-1:0] drn_q, drn_d, drn_inc;
  logic             flush_pnd_q, flush_pnd_d;
  logic             fclr_q, fclr_d;
  logic             stall_q, stall_d;

  logic [HALF-1:0]  ah_vld, ah_done;
  logic             rdy_ah;
  logic             clr_any;

  assign ah_vld  = arch_q ? lin_vld[ISQ_DEPTH-1:HALF]  : lin_vld[HALF-1:0];
  assign ah_done = arch_q ? lin_done[ISQ_DEPTH-1:HALF] : lin_done[HALF-1:0];
  // done bits of empty lines are masked by ah_vld
  assign rdy_ah  = (|ah_vld) && ((ah_vld & ~ah_done) == '0) && !brn_pnd;

  assign drn_inc = (drn_q == TMO_MAX) ? drn_q : drn_q + TMO_W'(1);

  // Next-state and bookkeeping for the switch sequence
  always_comb begin
    state_d     = state_q;
    arch_d      = arch_q;
    swt_cnt_d   = swt_cnt_q;
    tmo_d       = tmo_q;
    drn_d       = drn_q;
    flush_pnd_d = flush_pnd_q;
    fclr_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|ah_vld) state_d = S_DRAIN;
        // a flush held over from SWT/CLR merges with any new flush here
        if (flush || flush_pnd_q) fclr_d = 1'b1;
        flush_pnd_d = 1'b0;
      end
      S_DRAIN: begin
        drn_d = drn_inc;
        if (drn_inc == TMO_MAX) tmo_d = 1'b1;
        if (flush) begin
          fclr_d = 1'b1;
        end else if (rdy_ah) begin
          state_d = S_SWT;
          drn_d   = '0;
        end
      end
      S_SWT: begin
        arch_d    = ~arch_q;
        swt_cnt_d = swt_cnt_q + CNT_W'(1);
        state_d   = S_CLR;
        if (flush) flush_pnd_d = 1'b1;
      end
      S_CLR: begin
        state_d = S_IDLE;
        if (flush) flush_pnd_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    stall_d = (state_d == S_DRAIN) || (state_d == S_SWT);
  end

  // State and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      arch_q      <= 1'b0;
      swt_cnt_q   <= '0;
      tmo_q       <= 1'b0;
      drn_q       <= '0;
      flush_pnd_q <= 1'b0;
      fclr_q      <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      arch_q      <= arch_d;
      swt_cnt_q   <= swt_cnt_d;
      tmo_q       <= tmo_d;
      drn_q       <= drn_d;
      flush_pnd_q <= flush_pnd_d;
      fclr_q      <= fclr_d;
      stall_q     <= stall_d;
    end
  end

  // CLR clears the new SH (old AH) and a flush clears the current SH; with
  // arch stable in both cases they hit the same half, so one OR yields a
  // single pulse and top/mid can never be high together.
  assign clr_any     = (state_q == S_CLR) || fclr_q;
  assign top_clr     = clr_any && arch_q;
  assign mid_clr     = clr_any && !arch_q;
  assign arch_swt    = (state_q == S_SWT);
  assign arch        = arch_q;
  assign alloc_stall = stall_q;
  assign swt_cnt     = swt_cnt_q;
  assign tmo_err     = tmo_q;

endmodule

// File: tb/tb_seg_swt_ctl.sv
// Scenario bench for seg_swt_ctl: each task drives a cycle-by-cycle
// sequence, queues the expected outputs, and checks them after the edge.
module tb_seg_swt_ctl;

  localparam int D = 64;
  localparam int H = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [D-1:0] lin_vld = '0;
  logic [D-1:0] lin_done = '0;
  logic         brn_pnd = 1'b0;
  logic         flush = 1'b0;
  logic         arch_swt, arch, top_clr, mid_clr, alloc_stall, tmo_err;
  logic [15:0]  swt_cnt;

  // {arch_swt, arch, top_clr, mid_clr, alloc_stall, tmo_err, swt_cnt}
  logic [21:0]  obs, exp_v;
  logic [21:0]  sb[$];
  int           n_run = 0;
  int           n_fail = 0;
  bit           e_arch = 1'b0;
  bit           e_tmo = 1'b0;
  int unsigned  e_cnt = 0;

  seg_swt_ctl #(.ISQ_DEPTH(D), .TMO_CYC(1023), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .lin_vld(lin_vld), .lin_done(lin_done),
    .brn_pnd(brn_pnd), .flush(flush), .arch_swt(arch_swt), .arch(arch),
    .top_clr(top_clr), .mid_clr(mid_clr), .alloc_stall(alloc_stall),
    .swt_cnt(swt_cnt), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  assign obs = {arch_swt, arch, top_clr, mid_clr, alloc_stall, tmo_err, swt_cnt};

  function automatic logic [21:0] ev(bit swt, bit ar, bit top, bit mid, bit st,
                                     bit tmo, int unsigned cnt);
    return {swt, ar, top, mid, st, tmo, 16'(cnt)};
  endfunction

  function automatic logic [D-1:0] ah_mask(bit a, logic [H-1:0] m);
    return a ? {m, {H{1'b0}}} : {{H{1'b0}}, m};
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      rst = (s < 3);
      sb.push_back(ev(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_run++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset step %0d: got %h want %h", s, obs, exp_v);
      end
    end
  endtask

  task automatic test_switch();
    bit a;
    a = e_arch;
    for (int s = 0; s < 14; s++) begin
      if (s == 0)  lin_vld  = ah_mask(a, 32'hF);
      if (s == 10) lin_done = ah_mask(a, 32'hF);
      if (s == 11) begin lin_vld = '0; lin_done = '0; e_cnt++; end
      sb.push_back(ev(s == 10, (s >= 11) ? !a : a, (s == 11) && !a, (s == 11) && a,
                      s <= 10, e_tmo, e_cnt));
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_run++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL switch step %0d: got %h want %h", s, obs, exp_v);
      end
    end
    e_arch = !a;
  endtask

  task automatic test_flush_drain();
    bit a, shc;
    a = e_arch;
    for (int s = 0; s < 7; s++) begin
      flush = (s == 1) || (s == 3);
      if (s == 0) begin lin_vld = ah_mask(a, 32'h1); lin_done = '0; end
      if (s == 3) lin_done = ah_mask(a, 32'h1);
      if (s == 5) begin lin_vld = '0; lin_done = '0; e_cnt++; end
      shc = (s == 1) || (s == 3);
      sb.push_back(ev(s == 4, (s >= 5) ? !a : a,
                      (shc && a) || ((s == 5) && !a), (shc && !a) || ((s == 5) && a),
                      s <= 4, e_tmo, e_cnt));
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_run++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL flush_drain step %0d: got %h want %h", s, obs, exp_v);
      end
    end
    flush = 1'b0;
    e_arch = !a;
  endtask

  task automatic test_brn_block();
    bit a;
    a = e_arch;
    for (int s = 0; s < 23; s++) begin
      brn_pnd = (s < 20);
      if (s == 0) begin lin_vld = ah_mask(a, 32'hF); lin_done = ah_mask(a, 32'hF); end
      if (s == 21) begin lin_vld = '0; lin_done = '0; e_cnt++; end
      sb.push_back(ev(s == 20, (s >= 21) ? !a : a, (s == 21) && !a, (s == 21) && a,
                      s <= 20, e_tmo, e_cnt));
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_run++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL brn_block step %0d: got %h want %h", s, obs, exp_v);
      end
    end
    e_arch = !a;
  endtask

  task automatic test_flush_pending();
    bit a, clr;
    a = e_arch;
    for (int s = 0; s < 6; s++) begin
      flush = (s == 2);
      if (s == 0) begin lin_vld = ah_mask(a, 32'h2); lin_done = ah_mask(a, 32'h2); end
      if (s == 2) begin lin_vld = '0; lin_done = '0; e_cnt++; end
      // s2: CLR of old AH; s4: deferred flush clear of the now-current SH
      clr = (s == 2) || (s == 4);
      sb.push_back(ev(s == 1, (s >= 2) ? !a : a, clr && !a, clr && a,
                      s <= 1, e_tmo, e_cnt));
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_run++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL flush_pending step %0d: got %h want %h", s, obs, exp_v);
      end
    end
    flush = 1'b0;
    e_arch = !a;
  endtask

  task automatic test_timeout();
    bit a;
    a = e_arch;
    for (int s = 0; s < 1034; s++) begin
      if (s == 0) begin lin_vld = ah_mask(a, 32'h2); lin_done = ~lin_vld; end
      if (s == 1031) lin_done = ah_mask(a, 32'h2);
      if (s == 1032) begin lin_vld = '0; lin_done = '0; e_cnt++; end
      if (s >= 1023) e_tmo = 1'b1;
      sb.push_back(ev(s == 1031, (s >= 1032) ? !a : a, (s == 1032) && !a,
                      (s == 1032) && a, s <= 1031, e_tmo, e_cnt));
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_run++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL timeout step %0d: got %h want %h", s, obs, exp_v);
      end
    end
    e_arch = !a;
  endtask

  task automatic test_reset_mid_drain();
    bit a;
    a = e_arch;
    for (int s = 0; s < 5; s++) begin
      rst = (s >= 1) && (s <= 3);
      if (s == 0) lin_vld = ah_mask(a, 32'h100);
      if (s == 4) lin_vld = '0;
      if (s == 1) begin e_arch = 1'b0; e_cnt = 0; e_tmo = 1'b0; end
      sb.push_back(ev(0, e_arch, 0, 0, s == 0, e_tmo, e_cnt));
      @(posedge clk); @(negedge clk);
      exp_v = sb.pop_front(); n_run++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset_mid_drain step %0d: got %h want %h", s, obs, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_switch();
    test_flush_drain();
    test_brn_block();
    test_flush_pending();
    test_timeout();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_swt_ctl.md
Name: seg_swt_ctl

Overview:
- Sequences the two-segment rename-table unit: decides when the architectural half of the 64-entry issue queue has fully completed, then pulses arch_swt.
- The unit then loads the new segment header and flips which half is architectural.
- Clears the retired half so the queue can refill it, and services mispredict flushes of the speculative half.
- Sits between the issue queue (per-line status), branch unit (pending/flush) and the rename-table unit (arch_swt).

Parameters:
ISQ_DEPTH, 64, issue-queue lines; must be even; HALF = ISQ_DEPTH/2
TMO_CYC, 1023, max cycles in DRAIN before timeout flag (10-bit counter)
CNT_W, 16, width of switch counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lin_vld  in  ISQ_DEPTH  line holds an instruction
lin_done  in  ISQ_DEPTH  line's instruction completed (meaningful only when lin_vld)
brn_pnd  in  1  unresolved branch in flight
flush  in  1  mispredict; single-cycle pulse
arch_swt  out  1  one-cycle pulse to rename-table unit
arch  out  1  0: lines 0..HALF-1 architectural; 1: lines HALF..ISQ_DEPTH-1 architectural
top_clr  out  1  one-cycle clear of lines 0..HALF-1
mid_clr  out  1  one-cycle clear of lines HALF..ISQ_DEPTH-1
alloc_stall  out  1  queue must not write into the architectural half
swt_cnt  out  CNT_W  completed switches, wraps
tmo_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst high at posedge): state=IDLE, arch=0, arch_swt=0, top_clr=0, mid_clr=0, alloc_stall=0, swt_cnt=0, tmo_err=0, drain counter=0, flush_pnd=0. Reset overrides everything, in any state.
- Arch half (AH): lines 0..HALF-1 if arch=0, else HALF..ISQ_DEPTH-1. Spec half (SH) is the other half.
- rdy_ah (combinational): at least one lin_vld in AH, AND every AH line with lin_vld=1 has lin_done=1, AND brn_pnd=0.
- IDLE:
  - Any AH line with lin_vld=1 -> DRAIN; alloc_stall=1 from the next cycle.
  - Else remain in IDLE.
- DRAIN:
  - alloc_stall=1; drain counter increments each cycle, saturating at TMO_CYC.
  - When the counter reaches TMO_CYC, tmo_err sets (sticky until reset) and the FSM stays in DRAIN.
  - rdy_ah=1 -> SWT; counter cleared.
- SWT (exactly 1 cycle):
  - arch_swt=1; arch toggles at the end of the cycle; swt_cnt+1 (wraps at 2^CNT_W).
  - -> CLR.
- CLR (exactly 1 cycle):
  - Clear the old AH, which is now SH: top_clr=1 if the new arch=1, mid_clr=1 if the new arch=0.
  - alloc_stall=0.
  - -> IDLE.
- alloc_stall is a registered output: 1 in DRAIN and SWT, 0 in IDLE and CLR.
- Latency: rdy_ah first true in DRAIN at cycle N -> arch_swt at N+1 -> clr pulse at N+2 -> IDLE at N+3.
- Flush:
  - In IDLE or DRAIN: the next cycle pulses the SH clear (mid_clr if arch=0, top_clr if arch=1). State is unchanged.
  - A flush sampled in the same cycle that DRAIN->SWT is decided cancels the transition: stay in DRAIN, clear SH.
  - In SWT or CLR: latch flush_pnd. On return to IDLE, pulse the clear for the then-current SH one cycle later, then clear flush_pnd.
  - If a flush clear and a CLR clear target the same half in the same cycle, emit a single pulse.
- top_clr and mid_clr are never both 1 in one cycle.
- brn_pnd=1 blocks a switch indefinitely; the timeout counter still runs.
- lin_done on a line with lin_vld=0 is ignored.

Test Plan:
- Reset -> all outputs 0, arch=0, state IDLE; hold rst 3 cycles mid-DRAIN -> same values next cycle.
- arch=0, lin_vld[0..3]=1, lin_done low, then lin_done[0..3]=1 at cycle 10 with brn_pnd=0 -> arch_swt=1 at cycle 11, arch=1 and top_clr=1 at cycle 12, swt_cnt=1, alloc_stall 1->0 at cycle 12.
- Same as above but brn_pnd=1 until cycle 20 -> arch_swt at cycle 21, no earlier pulse.
- flush pulse in DRAIN with arch=1 -> top_clr=1 next cycle, mid_clr=0, state stays DRAIN, arch unchanged.
- flush coincident with rdy_ah -> no arch_swt that cycle, SH clear next cycle; rdy_ah still true -> arch_swt the following cycle.
- lin_vld[1]=1, lin_done=0 held 1023 cycles -> tmo_err=1 at cycle 1023 and stays 1; completing later still produces a normal switch.
